// File: rtl/conv_mac_sequencer.sv
// Sequencer for a single MAC computing a valid-mode KxK convolution over an NxN image.
// Issues X/W read addresses, drives MAC init/accumulate controls and streams results out.
module conv_mac_sequencer #(
    parameter int INW  = 16,
    parameter int OUTW = 64,
    parameter int N    = 8,
    parameter int K    = 3,
    localparam int XAW = (N * N > 1) ? $clog2(N * N) : 1,
    localparam int WAW = (K * K > 1) ? $clog2(K * K) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [INW-1:0]  bias,
    output logic                   busy,
    output logic                   done,
    output logic [XAW-1:0]         x_addr,
    input  logic signed [INW-1:0]  x_data,
    output logic [WAW-1:0]         w_addr,
    input  logic signed [INW-1:0]  w_data,
    output logic signed [INW-1:0]  mac_in0,
    output logic signed [INW-1:0]  mac_in1,
    output logic signed [INW-1:0]  mac_init_value,
    output logic                   mac_init_acc,
    output logic                   mac_input_valid,
    input  logic signed [OUTW-1:0] mac_out,
    output logic signed [OUTW-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int DW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [DW-1:0] M_LAST = DW'(N - K);
    localparam logic [DW-1:0] K_LAST = DW'(K - 1);

    logic [1:0]    state;
    logic [DW-1:0] r, c, i, j;
    logic          tap_q;
    logic          done_q;
    logic          last_tap;
    logic          last_pos;

    assign last_tap = (i == K_LAST) && (j == K_LAST);
    assign last_pos = (r == M_LAST) && (c == M_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            r      <= '0;
            c      <= '0;
            i      <= '0;
            j      <= '0;
            tap_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: registered tap flag lines the accumulate enable up with the 1-cycle memory read.
            tap_q  <= (state == S_LOAD);
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (last_tap) begin
                        i     <= '0;
                        j     <= '0;
                        state <= S_DRAIN;
                    end else if (j == K_LAST) begin
                        j <= '0;
                        i <= i + DW'(1);
                    end else begin
                        j <= j + DW'(1);
                    end
                end
                S_DRAIN: state <= S_OUT;
                S_OUT: begin
                    if (out_ready) begin
                        if (last_pos) begin
                            r      <= '0;
                            c      <= '0;
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                            if (c == M_LAST) begin
                                c <= '0;
                                r <= r + DW'(1);
                            end else begin
                                c <= c + DW'(1);
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Addresses are only driven during LOAD so the memories see no activity while stalled.
    assign x_addr = (state == S_LOAD)
                  ? XAW'((XAW'(r) + XAW'(i)) * XAW'(N) + XAW'(c) + XAW'(j))
                  : '0;
    assign w_addr = (state == S_LOAD) ? WAW'(WAW'(i) * WAW'(K) + WAW'(j)) : '0;

    assign mac_init_acc    = (state == S_LOAD) && (i == '0) && (j == '0);
    assign mac_input_valid = tap_q;
    assign mac_in0         = x_data;
    assign mac_in1         = w_data;
    assign mac_init_value  = bias;

    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign out_valid = (state == S_OUT);
    assign out_data  = mac_out;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer: three sizes (4/3, 4/4, 2/1) with bench-side
// memories and MAC; expected results are queued at start and popped on each handshake.
module tb_conv_mac_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic out_ready;
    logic signed [15:0] bias;
    logic start_a, start_b, start_c;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic signed [63:0] exp_q[$];

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- instance A: N=4, K=3 ----------------
    logic [3:0] x_addr_a, w_addr_a;
    logic signed [15:0] xd_a, wd_a, mi0_a, mi1_a, miv_a;
    logic init_acc_a, valid_a, busy_a, done_a, out_valid_a;
    logic signed [63:0] acc_a, out_data_a;
    logic signed [15:0] xa[16], wa[16];

    conv_mac_sequencer #(.INW(16), .OUTW(64), .N(4), .K(3)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .bias(bias), .busy(busy_a), .done(done_a),
        .x_addr(x_addr_a), .x_data(xd_a), .w_addr(w_addr_a), .w_data(wd_a),
        .mac_in0(mi0_a), .mac_in1(mi1_a), .mac_init_value(miv_a), .mac_init_acc(init_acc_a),
        .mac_input_valid(valid_a), .mac_out(acc_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    always @(posedge clk) begin
        xd_a <= xa[x_addr_a];
        wd_a <= wa[w_addr_a];
        if (init_acc_a)   acc_a <= 64'(miv_a);
        else if (valid_a) acc_a <= acc_a + 64'(mi0_a) * 64'(mi1_a);
    end

    // ---------------- instance B: N=4, K=4 ----------------
    logic [3:0] x_addr_b, w_addr_b;
    logic signed [15:0] xd_b, wd_b, mi0_b, mi1_b, miv_b;
    logic init_acc_b, valid_b, busy_b, done_b, out_valid_b;
    logic signed [63:0] acc_b, out_data_b;
    logic signed [15:0] xb[16], wb[16];

    conv_mac_sequencer #(.INW(16), .OUTW(64), .N(4), .K(4)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .bias(bias), .busy(busy_b), .done(done_b),
        .x_addr(x_addr_b), .x_data(xd_b), .w_addr(w_addr_b), .w_data(wd_b),
        .mac_in0(mi0_b), .mac_in1(mi1_b), .mac_init_value(miv_b), .mac_init_acc(init_acc_b),
        .mac_input_valid(valid_b), .mac_out(acc_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    always @(posedge clk) begin
        xd_b <= xb[x_addr_b];
        wd_b <= wb[w_addr_b];
        if (init_acc_b)   acc_b <= 64'(miv_b);
        else if (valid_b) acc_b <= acc_b + 64'(mi0_b) * 64'(mi1_b);
    end

    // ---------------- instance C: N=2, K=1 ----------------
    logic [1:0] x_addr_c;
    logic [0:0] w_addr_c;
    logic signed [15:0] xd_c, wd_c, mi0_c, mi1_c, miv_c;
    logic init_acc_c, valid_c, busy_c, done_c, out_valid_c;
    logic signed [63:0] acc_c, out_data_c;
    logic signed [15:0] xc[4], wc[2];

    conv_mac_sequencer #(.INW(16), .OUTW(64), .N(2), .K(1)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .bias(bias), .busy(busy_c), .done(done_c),
        .x_addr(x_addr_c), .x_data(xd_c), .w_addr(w_addr_c), .w_data(wd_c),
        .mac_in0(mi0_c), .mac_in1(mi1_c), .mac_init_value(miv_c), .mac_init_acc(init_acc_c),
        .mac_input_valid(valid_c), .mac_out(acc_c), .out_data(out_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready)
    );

    always @(posedge clk) begin
        xd_c <= xc[x_addr_c];
        wd_c <= wc[w_addr_c];
        if (init_acc_c)   acc_c <= 64'(miv_c);
        else if (valid_c) acc_c <= acc_c + 64'(mi0_c) * 64'(mi1_c);
    end

    // ---------------- monitors ----------------
    int vcount_a = 0;
    logic stalled = 1'b0;
    logic signed [63:0] held;

    always @(negedge clk) begin
        if (valid_a) vcount_a++;
        if (out_valid_a && !out_ready) begin
            if (stalled) check("stall_hold_a", out_data_a, held);
            check("stall_mac_idle_a", valid_a, 0);
            check("stall_init_idle_a", init_acc_a, 0);
            held    = out_data_a;
            stalled = 1'b1;
        end else begin
            stalled = 1'b0;
        end
        if (out_valid_a && out_ready) begin
            if (exp_q.size() == 0) check("extra_out_a", out_data_a, 64'sd999999);
            else check("out_a", out_data_a, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (out_valid_b && out_ready) begin
            if (exp_q.size() == 0) check("extra_out_b", out_data_b, 64'sd999999);
            else check("out_b", out_data_b, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (out_valid_c && out_ready) begin
            if (exp_q.size() == 0) check("extra_out_c", out_data_c, 64'sd999999);
            else check("out_c", out_data_c, exp_q.pop_front());
        end
    end

    // ---------------- helpers ----------------
    function automatic logic sel(input int w);
        case (w)
            0: return out_valid_a;
            1: return out_valid_b;
            2: return out_valid_c;
            3: return done_a;
            4: return done_b;
            5: return done_c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input string tag, output int n);
        n = 0;
        while (!sel(w) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_seen"}, sel(w), 1);
    endtask

    task automatic pulse_start(input int w);
        @(posedge clk);
        #1;
        case (w)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic load_ramp_a();
        for (int a = 0; a < 16; a++) begin
            xa[a] = 16'(a);
            wa[a] = 16'sd1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        out_ready = 1'b1;
        bias = 16'sd0;
        load_ramp_a();
        for (int a = 0; a < 16; a++) begin
            xb[a] = 16'sd1;
            wb[a] = 16'sd1;
        end
        for (int a = 0; a < 4; a++) xc[a] = 16'(a);
        wc[0] = 16'sd3;
        wc[1] = 16'sd3;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_init_acc", init_acc_a, 0);
        check("rst_input_valid", valid_a, 0);
        check("rst_x_addr", x_addr_a, 0);
        check("rst_w_addr", w_addr_a, 0);
        reset = 1'b0;

        // Basic frame with timing
        exp_q.push_back(45); exp_q.push_back(54); exp_q.push_back(81); exp_q.push_back(90);
        base = vcount_a;
        pulse_start(0);
        check("busy_cycle1", busy_a, 1);
        check("init_acc_cycle1", init_acc_a, 1);
        wait_for(0, "first_valid", n);
        check("first_valid_cycle", n + 1, 11);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            wait_for(0, "next_valid", n);
            check("output_spacing", n + 1, 11);
        end
        @(posedge clk);
        #1;
        check("done_pulse", done_a, 1);
        check("busy_fall", busy_a, 0);
        @(posedge clk);
        #1;
        check("done_single", done_a, 0);
        check("basic_queue_empty", exp_q.size(), 0);
        check("basic_tap_count", vcount_a - base, 36);

        // Bias and signed operands
        for (int a = 0; a < 16; a++) begin
            xa[a] = -16'sd3;
            wa[a] = 16'sd2;
        end
        bias = -16'sd1;
        repeat (4) exp_q.push_back(-55);
        pulse_start(0);
        wait_for(3, "signed_done", n);
        check("signed_queue_empty", exp_q.size(), 0);

        // Backpressure
        load_ramp_a();
        bias = 16'sd0;
        out_ready = 1'b0;
        exp_q.push_back(45); exp_q.push_back(54); exp_q.push_back(81); exp_q.push_back(90);
        base = vcount_a;
        pulse_start(0);
        for (int k = 0; k < 4; k++) begin
            wait_for(0, "bp_valid", n);
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        wait_for(3, "bp_done", n);
        out_ready = 1'b1;
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_tap_count", vcount_a - base, 36);

        // Reset during the second output's LOAD
        exp_q.push_back(45); exp_q.push_back(54); exp_q.push_back(81); exp_q.push_back(90);
        pulse_start(0);
        wait_for(0, "pre_reset_valid", n);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_out_valid", out_valid_a, 0);
        check("mid_rst_init_acc", init_acc_a, 0);
        check("mid_rst_input_valid", valid_a, 0);
        check("mid_rst_x_addr", x_addr_a, 0);
        check("mid_rst_w_addr", w_addr_a, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("start_during_reset_ignored", busy_a, 0);
        exp_q.push_back(45); exp_q.push_back(54); exp_q.push_back(81); exp_q.push_back(90);
        pulse_start(0);
        wait_for(3, "post_reset_done", n);
        check("post_reset_queue_empty", exp_q.size(), 0);

        // K = N = 4: single output
        exp_q.push_back(16);
        pulse_start(1);
        wait_for(1, "kn_valid", n);
        check("kn_first_valid_cycle", n + 1, 18);
        wait_for(4, "kn_done", n);
        check("kn_queue_empty", exp_q.size(), 0);

        // K = 1, N = 2, with a start pulsed while busy
        exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(6); exp_q.push_back(9);
        pulse_start(2);
        pulse_start(2);
        check("k1_busy_after_extra_start", busy_c, 1);
        wait_for(5, "k1_done", n);
        check("k1_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("k1_no_restart", busy_c, 0);
        check("k1_done_single", done_c, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
